// File: rtl/uart_rx_framer.sv
// Oversampling UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined),
// majority-voted bits, held-valid/ack byte output with framing and overrun pulses.
module uart_rx_framer #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam int M       = OVERSAMPLE / 2;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SC_A     = SW'(M - 1);
   localparam logic [SW-1:0] SC_B     = SW'(M);
   localparam logic [SW-1:0] SC_C     = SW'(M + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   state_t        state;
   logic          sync1, rxs;
   logic [DW-1:0] divc;
   logic [SW-1:0] sc;
   logic          v0, v1, bit_v;
   logic [2:0]    bidx;
   logic [7:0]    shift;
   logic          done;
   logic          tick, vote;
`ifdef UART_RX_PARITY_EN
   logic          perr;
`endif

   assign tick = (state != IDLE) && (divc == DIV_LAST);
   assign vote = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
   assign busy = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         divc      <= '0;
         sc        <= '0;
         v0        <= 1'b1;
         v1        <= 1'b1;
         bit_v     <= 1'b1;
         bidx      <= '0;
         shift     <= '0;
         done      <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr      <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         done      <= 1'b0;

         if (state == IDLE || tick) divc <= '0;
         else                       divc <= divc + 1'b1;

         if (tick) begin
            if (sc == SC_A) v0 <= rxs;
            if (sc == SC_B) v1 <= rxs;
            if (sc == SC_C) bit_v <= vote;
            sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
         end

         // a completed byte always wins over a same-cycle ack, so valid stays up
         if (done) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            overrun  <= rx_valid & ~rx_ack;
         end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               sc <= '0;
`ifdef UART_RX_PARITY_EN
               perr <= 1'b0;
`endif
               if (!rxs) state <= START;
            end
            START: begin
               if (tick && sc == SC_C && vote) state <= IDLE;
               else if (tick && sc == SC_LAST) begin
                  state <= DATA;
                  bidx  <= '0;
               end
            end
            DATA: begin
               if (tick && sc == SC_LAST) begin
                  shift <= {bit_v, shift[7:1]};
                  bidx  <= bidx + 1'b1;
`ifdef UART_RX_PARITY_EN
                  if (bidx == 3'd7) state <= PARITY;
`else
                  if (bidx == 3'd7) state <= STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick && sc == SC_LAST) begin
                  if (^shift ^ bit_v) begin
                     frame_err <= 1'b1;
                     perr      <= 1'b1;
                  end
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               // decide mid stop bit so a slightly fast sender cannot clip it
               if (tick && sc == SC_C) begin
                  if (vote) begin
`ifdef UART_RX_PARITY_EN
                     done <= ~perr;
`else
                     done <= 1'b1;
`endif
                     state <= IDLE;
                  end else begin
`ifdef UART_RX_PARITY_EN
                     frame_err <= ~perr;
`else
                     frame_err <= 1'b1;
`endif
                     state <= BRK;
                  end
               end
            end
            BRK: if (rxs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 16 clocks/bit with a frame-level reference model
// that predicts byte delivery, overrun and frame_err pulses from the frames sent.
module tb_uart_rx_framer;

   logic       clock, reset, rxd, rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, busy;

   uart_rx_framer #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16)) dut (
      .clock(clock), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ack(rx_ack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   // Edges from driving the start bit to rx_valid: 2 sync + 1 idle detect + 16 per bit
   // before stop + mid-stop sample (M+1) + decision edge + output register.
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN   = 1'b1;
   localparam int NBITS    = 11;
   localparam int LAT      = 174;
   localparam int PERR_LAT = 163;
`else
   localparam bit PAR_EN   = 1'b0;
   localparam int NBITS    = 10;
   localparam int LAT      = 158;
   localparam int PERR_LAT = 0;
`endif

   typedef struct {int cyc; bit is_err; logic [7:0] data;} ev_t;
   ev_t evq[$];

   int         checks = 0, passed = 0;
   int         cyc = 0, rise_cyc = 0, ferr_cnt = 0, ovr_cnt = 0;
   logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, prev_v = 1'b0;
   logic [7:0] m_data = 8'h00;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else passed++;
   endtask

   // Reference model: applies predicted frame outcomes at the edge they are due.
   always @(posedge clock) begin
      cyc++;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (reset) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         evq.delete();
      end else begin
         if (evq.size() > 0 && evq[0].cyc == cyc && !evq[0].is_err) begin
            m_ovr   = m_valid && !rx_ack;
            m_data  = evq[0].data;
            m_valid = 1'b1;
            void'(evq.pop_front());
         end else begin
            if (m_valid && rx_ack) m_valid = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc && evq[0].is_err) begin
               m_ferr = 1'b1;
               void'(evq.pop_front());
            end
         end
      end
   end

   always @(negedge clock) begin
      #1;
      chk("rx_valid", rx_valid, reset ? 1'b0 : m_valid);
      chk("rx_data", rx_data, reset ? 8'h00 : m_data);
      chk("frame_err", frame_err, reset ? 1'b0 : m_ferr);
      chk("overrun", overrun, reset ? 1'b0 : m_ovr);
      if (rx_valid && !prev_v) rise_cyc = cyc;
      prev_v = rx_valid;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      @(negedge clock);
      rx_ack = 1'b0;
   endtask

   // Called at a negedge; glitch_t inverts rxd for one clock at that offset into the frame.
   task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_flip,
                             input int glitch_t);
      logic [NBITS-1:0] fr;
      ev_t e;
`ifdef UART_RX_PARITY_EN
      fr = {stop_b, ^d ^ par_flip, d, 1'b0};
`else
      fr = {stop_b, d, 1'b0};
`endif
      e.data = d;
      if (PAR_EN && par_flip) begin e.cyc = cyc + PERR_LAT; e.is_err = 1'b1; end
      else if (!stop_b)       begin e.cyc = cyc + LAT - 1;  e.is_err = 1'b1; end
      else                    begin e.cyc = cyc + LAT;      e.is_err = 1'b0; end
      evq.push_back(e);
      for (int j = 0; j < NBITS; j++)
         for (int k = 0; k < 16; k++) begin
            rxd = fr[j] ^ ((j * 16 + k) == glitch_t);
            @(negedge clock);
         end
   endtask

   initial begin
      int e0, c_done;
      reset = 1'b1; rxd = 1'b1; rx_ack = 1'b0;
      idle(3);
      chk("reset rx_data", rx_data, 8'h00);
      chk("reset rx_valid", rx_valid, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset pulses", {frame_err, overrun}, 2'b00);
      reset = 1'b0;
      idle(5);

      e0 = cyc;
      send_frame(8'hA7, 1'b1, 1'b0, -1);
      chk("A7 latency", rise_cyc - e0, LAT);
      chk("A7 data", rx_data, 8'hA7);
      chk("A7 busy after", busy, 1'b0);
      chk("A7 no errors", ferr_cnt + ovr_cnt, 0);
      ack_pulse();
      chk("ack clears valid", rx_valid, 1'b0);

      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(30);
      chk("short start busy", busy, 1'b0);
      chk("short start no ferr", ferr_cnt, 0);

      send_frame(8'h3C, 1'b0, 1'b0, -1);
      idle(40);
      chk("break busy", busy, 1'b1);
      chk("break ferr once", ferr_cnt, 1);
      rxd = 1'b1;
      idle(5);
      chk("break released", busy, 1'b0);
      chk("break no valid", rx_valid, 1'b0);

      send_frame(8'h11, 1'b1, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b0, -1);
      idle(4);
      chk("overrun data", rx_data, 8'h22);
      chk("overrun valid", rx_valid, 1'b1);
      chk("overrun once", ovr_cnt, 1);
      ack_pulse();

      send_frame(8'h11, 1'b1, 1'b0, -1);
      c_done = cyc + LAT;
      fork
         send_frame(8'h22, 1'b1, 1'b0, -1);
         begin
            while (cyc < c_done - 1) @(negedge clock);
            ack_pulse();
         end
      join
      idle(4);
      chk("ack on completion no overrun", ovr_cnt, 1);
      chk("ack on completion valid", rx_valid, 1'b1);
      chk("ack on completion data", rx_data, 8'h22);
      ack_pulse();

      send_frame(8'h55, 1'b1, 1'b0, 4 * 16 + 8);
      idle(4);
      chk("glitch vote data", rx_data, 8'h55);
      ack_pulse();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, -1);
      idle(4);
      chk("parity ok data", rx_data, 8'h07);
      ack_pulse();
      send_frame(8'h07, 1'b1, 1'b1, -1);
      idle(4);
      chk("parity err ferr", ferr_cnt, 2);
      chk("parity err no valid", rx_valid, 1'b0);
`endif

      rxd = 1'b0;
      idle(50);
      chk("mid-frame busy", busy, 1'b1);
      reset = 1'b1;
      rxd   = 1'b1;
      idle(3);
      chk("mid reset data", rx_data, 8'h00);
      chk("mid reset busy", busy, 1'b0);
      reset = 1'b0;
      idle(10);
      send_frame(8'h5A, 1'b1, 1'b0, -1);
      idle(4);
      chk("post reset data", rx_data, 8'h5A);
      chk("post reset valid", rx_valid, 1'b1);
      idle(5);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
